// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the program counter, prefetches into a
// 2-entry {pc, instr} buffer, hands instructions to decode over valid/ready,
// and handles redirects and halting.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_RUN     | fetching; a push happens whenever the buffer has room
// S_HALTED  | no more pushes; the buffer keeps draining to decode
module instr_fetch_ctrl #(
  parameter int                  ADDR_W   = 12,
  parameter int                  INSTR_W  = 16,
  parameter logic [ADDR_W-1:0]   RESET_PC = 12'h000,
  parameter logic [INSTR_W-1:0]  HALT_OP  = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  instr_addr,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  input  logic               halt_req,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               out_ready,
  output logic               halted
);

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  pc_mem_q [2];
  logic [ADDR_W-1:0]  pc_mem_d [2];
  logic [INSTR_W-1:0] ins_mem_q [2];
  logic [INSTR_W-1:0] ins_mem_d [2];
  logic               head_q, head_d;
  logic [1:0]         count_q, count_d;
  logic               pop;
  logic               push;
  logic               tail;

  assign instr_addr = fetch_pc_q;
  assign out_valid  = (count_q != 2'd0);
  assign out_instr  = ins_mem_q[head_q];
  assign out_pc     = pc_mem_q[head_q];
  assign halted     = (state_q == S_HALTED) && (count_q == 2'd0);

  // Next-state: redirect wins, otherwise pop/push/halt bookkeeping.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    count_d    = count_q;
    pc_mem_d   = pc_mem_q;
    ins_mem_d  = ins_mem_q;

    pop  = out_valid && out_ready;
    // halt_req without a redirect suppresses the push in the same cycle.
    push = (state_q == S_RUN) && !redirect_valid && !halt_req &&
           ((count_q != 2'd2) || pop);
    // Free slot: head+count modulo 2; at count 2 with a pop it is the head slot.
    tail = head_q ^ count_q[0];

    if (redirect_valid) begin
      count_d    = 2'd0;
      head_d     = 1'b0;
      fetch_pc_d = redirect_addr;
      state_d    = halt_req ? S_HALTED : S_RUN;
    end else begin
      if ((state_q == S_RUN) && halt_req) begin
        state_d = S_HALTED;
      end
      if (pop) begin
        head_d = ~head_q;
      end
      if (push) begin
        pc_mem_d[tail]  = fetch_pc_q;
        ins_mem_d[tail] = instr_in;
        fetch_pc_d      = fetch_pc_q + ADDR_W'(1);
        if (instr_in == HALT_OP) begin
          state_d = S_HALTED;
        end
      end
      count_d = count_q + 2'(push) - 2'(pop);
    end
  end

  // State, program counter and prefetch buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      fetch_pc_q <= RESET_PC;
      head_q     <= 1'b0;
      count_q    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        pc_mem_q[i]  <= '0;
        ins_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      count_q    <= count_d;
      pc_mem_q   <= pc_mem_d;
      ins_mem_q  <= ins_mem_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] instr_addr;
  logic [15:0] instr_in;
  logic        redirect_valid;
  logic [11:0] redirect_addr;
  logic        halt_req;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [11:0] out_pc;
  logic        out_ready;
  logic        halted;

  logic [15:0] mem [4096];
  assign instr_in = mem[instr_addr];

  int total  = 0;
  int passed = 0;

  typedef struct packed {
    logic [11:0] pc;
    logic [15:0] ins;
  } ent_t;

  // Reference model: the buffer as a queue, the fetch pointer, a halt flag.
  ent_t q[$];
  int   m_pc;
  bit   m_halt;

  instr_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_addr     (instr_addr),
    .instr_in       (instr_in),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .halt_req       (halt_req),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  task automatic fill_linear();
    for (int a = 0; a < 4096; a++) mem[a] = 16'(a) + 16'h1000;
  endtask

  // Asynchronous reset pulse spanning one rising edge; model restarts too.
  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 12'h000;
    halt_req       = 1'b0;
    out_ready      = 1'b0;
    q.delete();
    m_pc   = 0;
    m_halt = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Advance the model by one cycle with the current inputs, then the DUT.
  task automatic step();
    bit pop;
    pop = (q.size() != 0) && out_ready;
    if (redirect_valid) begin
      q.delete();
      m_pc   = int'(redirect_addr);
      m_halt = halt_req;
    end else begin
      if (pop) void'(q.pop_front());
      if (!m_halt && halt_req) begin
        m_halt = 1'b1;
      end else if (!m_halt && q.size() < 2) begin
        q.push_back(ent_t'{pc: 12'(m_pc), ins: mem[m_pc]});
        if (mem[m_pc] == 16'hFFFF) m_halt = 1'b1;
        m_pc = (m_pc + 1) % 4096;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    fill_linear();
    rst_n = 1'b1; redirect_valid = 1'b0; redirect_addr = 12'h000;
    halt_req = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++; if (instr_addr !== 12'h000) $display("FAIL reset_addr: got %h want 000", instr_addr); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passed++;
    total++; if (out_instr !== 16'h0000) $display("FAIL reset_instr: got %h want 0000", out_instr); else passed++;
    total++; if (out_pc !== 12'h000) $display("FAIL reset_pc: got %h want 000", out_pc); else passed++;
    total++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else passed++;
    @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_hold_valid: got %b want 0", out_valid); else passed++;
    rst_n = 1'b1;
    q.delete(); m_pc = 0; m_halt = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      total++; if (out_valid !== 1'b1) $display("FAIL stream_valid[%0d]: got %b want 1", i, out_valid); else passed++;
      total++; if (out_pc !== 12'(i)) $display("FAIL stream_pc[%0d]: got %h want %h", i, out_pc, 12'(i)); else passed++;
      total++; if (out_instr !== 16'h1000 + 16'(i)) $display("FAIL stream_instr[%0d]: got %h want %h", i, out_instr, 16'h1000 + 16'(i)); else passed++;
      total++; if (instr_addr !== 12'(i + 1)) $display("FAIL stream_addr[%0d]: got %h want %h", i, instr_addr, 12'(i + 1)); else passed++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    repeat (5) step();
    total++; if (instr_addr !== 12'h002) $display("FAIL bp_addr: got %h want 002", instr_addr); else passed++;
    total++; if (out_pc !== 12'h000) $display("FAIL bp_head_pc: got %h want 000", out_pc); else passed++;
    total++; if (out_instr !== 16'h1000) $display("FAIL bp_head_instr: got %h want 1000", out_instr); else passed++;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (out_valid !== 1'b1) $display("FAIL bp_drain_valid[%0d]: got %b want 1", i, out_valid); else passed++;
      total++; if (out_pc !== 12'(i)) $display("FAIL bp_drain_pc[%0d]: got %h want %h", i, out_pc, 12'(i)); else passed++;
      step();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    out_ready = 1'b0;
    repeat (3) step();
    redirect_valid = 1'b1; redirect_addr = 12'h0A5; out_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL redir_bubble: got %b want 0", out_valid); else passed++;
    total++; if (instr_addr !== 12'h0A5) $display("FAIL redir_addr: got %h want 0a5", instr_addr); else passed++;
    step();
    total++; if (out_valid !== 1'b1) $display("FAIL redir_valid: got %b want 1", out_valid); else passed++;
    total++; if (out_pc !== 12'h0A5) $display("FAIL redir_pc: got %h want 0a5", out_pc); else passed++;
    total++; if (out_instr !== 16'h10A5) $display("FAIL redir_instr: got %h want 10a5", out_instr); else passed++;
    step();
    total++; if (out_pc !== 12'h0A6) $display("FAIL redir_next_pc: got %h want 0a6", out_pc); else passed++;
  endtask

  task automatic test_wrap();
    logic [11:0] exp_pc;
    redirect_valid = 1'b1; redirect_addr = 12'hFFE; out_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    step();
    exp_pc = 12'hFFE;
    for (int i = 0; i < 4; i++) begin
      total++; if (out_pc !== exp_pc) $display("FAIL wrap_pc[%0d]: got %h want %h", i, out_pc, exp_pc); else passed++;
      total++; if (out_instr !== 16'(exp_pc) + 16'h1000) $display("FAIL wrap_instr[%0d]: got %h want %h", i, out_instr, 16'(exp_pc) + 16'h1000); else passed++;
      exp_pc = exp_pc + 12'h001;
      step();
    end
  endtask

  task automatic test_halt_op();
    mem[3] = 16'hFFFF;
    do_reset();
    out_ready = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      total++; if (out_pc !== 12'(i)) $display("FAIL hop_pc[%0d]: got %h want %h", i, out_pc, 12'(i)); else passed++;
      total++; if (out_instr !== ((i == 3) ? 16'hFFFF : 16'h1000 + 16'(i))) $display("FAIL hop_instr[%0d]: got %h", i, out_instr); else passed++;
      step();
    end
    repeat (3) step();
    total++; if (instr_addr !== 12'h004) $display("FAIL hop_addr: got %h want 004", instr_addr); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL hop_empty: got %b want 0", out_valid); else passed++;
    total++; if (halted !== 1'b1) $display("FAIL hop_halted: got %b want 1", halted); else passed++;
    redirect_valid = 1'b1; redirect_addr = 12'h010;
    step();
    redirect_valid = 1'b0;
    total++; if (halted !== 1'b0) $display("FAIL hop_resume_halted: got %b want 0", halted); else passed++;
    total++; if (instr_addr !== 12'h010) $display("FAIL hop_resume_addr: got %h want 010", instr_addr); else passed++;
    step();
    total++; if (out_pc !== 12'h010) $display("FAIL hop_resume_pc: got %h want 010", out_pc); else passed++;
    mem[3] = 16'h1003;
  endtask

  task automatic test_halt_req();
    do_reset();
    out_ready = 1'b0;
    step();
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    total++; if (out_valid !== 1'b1) $display("FAIL hreq_valid: got %b want 1", out_valid); else passed++;
    total++; if (halted !== 1'b0) $display("FAIL hreq_not_empty: got %b want 0", halted); else passed++;
    repeat (3) step();
    total++; if (instr_addr !== 12'h001) $display("FAIL hreq_addr: got %h want 001", instr_addr); else passed++;
    out_ready = 1'b1;
    step();
    total++; if (halted !== 1'b1) $display("FAIL hreq_halted: got %b want 1", halted); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL hreq_empty: got %b want 0", out_valid); else passed++;
    redirect_valid = 1'b1; redirect_addr = 12'h020; halt_req = 1'b1;
    step();
    redirect_valid = 1'b0; halt_req = 1'b0;
    total++; if (instr_addr !== 12'h020) $display("FAIL hboth_addr: got %h want 020", instr_addr); else passed++;
    total++; if (halted !== 1'b1) $display("FAIL hboth_halted: got %b want 1", halted); else passed++;
    repeat (3) step();
    total++; if (instr_addr !== 12'h020) $display("FAIL hboth_stay_addr: got %h want 020", instr_addr); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL hboth_no_push: got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int a = 0; a < 4096; a++)
      mem[a] = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_addr  = 12'($urandom);
      halt_req       = ($urandom_range(0, 31) == 0);
      step();
      total++; if (instr_addr !== 12'(m_pc)) begin $display("FAIL rnd_addr@%0d: got %h want %h", c, instr_addr, 12'(m_pc)); errs++; end else passed++;
      total++; if (out_valid !== (q.size() != 0)) begin $display("FAIL rnd_valid@%0d: got %b want %b", c, out_valid, q.size() != 0); errs++; end else passed++;
      total++; if (halted !== (m_halt && q.size() == 0)) begin $display("FAIL rnd_halted@%0d: got %b want %b", c, halted, m_halt && q.size() == 0); errs++; end else passed++;
      if (q.size() != 0) begin
        total++; if (out_pc !== q[0].pc) begin $display("FAIL rnd_pc@%0d: got %h want %h", c, out_pc, q[0].pc); errs++; end else passed++;
        total++; if (out_instr !== q[0].ins) begin $display("FAIL rnd_instr@%0d: got %h want %h", c, out_instr, q[0].ins); errs++; end else passed++;
      end
      if (errs > 20) break;
    end
    redirect_valid = 1'b0;
    halt_req       = 1'b0;
  endtask

  task automatic test_reset_midop();
    fill_linear();
    do_reset();
    out_ready = 1'b1;
    repeat (4) step();
    redirect_valid = 1'b1; redirect_addr = 12'h300;
    #3 rst_n = 1'b0;
    #1;
    total++; if (instr_addr !== 12'h000) $display("FAIL midrst_addr: got %h want 000", instr_addr); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", out_valid); else passed++;
    redirect_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete(); m_pc = 0; m_halt = 1'b0;
    out_ready = 1'b1;
    step();
    total++; if (out_pc !== 12'h000) $display("FAIL midrst_restart_pc: got %h want 000", out_pc); else passed++;
    total++; if (instr_addr !== 12'h001) $display("FAIL midrst_restart_addr: got %h want 001", instr_addr); else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt_op();
    test_halt_req();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
